// File: rtl/clock_screen_pkg.sv
// Shared encodings for the clock screen: display modes, controller states and
// the BCD limits of every editable field.
package clock_screen_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_HORA   = 2'd1;
    localparam logic [1:0] MODE_FECHA  = 2'd2;
    localparam logic [1:0] MODE_TIMER  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_WRITE = 2'd2
    } cfg_state_t;

    localparam logic [7:0] HH_MIN   = 8'h00;
    localparam logic [7:0] HH_MAX   = 8'h23;
    localparam logic [7:0] MS_MIN   = 8'h00;
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] MES_MIN  = 8'h01;
    localparam logic [7:0] MES_MAX  = 8'h12;
    localparam logic [7:0] YEAR_MIN = 8'h00;
    localparam logic [7:0] YEAR_MAX = 8'h99;

    // Field 0 is the leftmost field (HH or DAY).
    function automatic logic [7:0] field_min(input logic [1:0] mode, input logic [1:0] field);
        if (mode == MODE_FECHA) begin
            case (field)
                2'd0:    return DAY_MIN;
                2'd1:    return MES_MIN;
                default: return YEAR_MIN;
            endcase
        end
        return (field == 2'd0) ? HH_MIN : MS_MIN;
    endfunction

    function automatic logic [7:0] field_max(input logic [1:0] mode, input logic [1:0] field);
        if (mode == MODE_FECHA) begin
            case (field)
                2'd0:    return DAY_MAX;
                2'd1:    return MES_MAX;
                default: return YEAR_MAX;
            endcase
        end
        return (field == 2'd0) ? HH_MAX : MS_MAX;
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// One-step BCD increment/decrement of a two-digit field, wrapping between
// min_val and max_val.
module bcd_field_step (
    input  logic [7:0] value,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    input  logic       inc,
    output logic [7:0] next_val
);

    // Valid BCD orders the same as binary, so plain compares find the limits.
    always_comb begin
        next_val = value;
        if (inc) begin
            if (value >= max_val)
                next_val = min_val;
            else if (value[3:0] == 4'd9)
                next_val = {value[7:4] + 4'd1, 4'd0};
            else
                next_val = {value[7:4], value[3:0] + 4'd1};
        end else begin
            if (value <= min_val)
                next_val = max_val;
            else if (value[3:0] == 4'd0)
                next_val = {value[7:4] - 4'd1, 4'd9};
            else
                next_val = {value[7:4], value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/config_mode_ctrl.sv
// Configuration-mode controller: button-driven field editing of time, date and
// timer values, committed to the RTC through a req/ack write handshake.
module config_mode_ctrl
    import clock_screen_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [23:0] live_hms,
    input  logic [23:0] live_date,
    input  logic [23:0] live_timer,
    input  logic        wr_ack,
    output logic [1:0]  config_mode,
    output logic [1:0]  cursor_location,
    output logic [23:0] edit_buf,
    output logic        edit_valid,
    output logic        wr_req,
    output logic [1:0]  wr_mode,
    output logic [23:0] wr_data
);

    localparam logic [29:0] TMO_LAST = 30'(TIMEOUT_CYCLES - 1);

    cfg_state_t  state_q, state_d;
    logic [29:0] tmo_q, tmo_d;
    logic [1:0]  config_mode_d, cursor_d, wr_mode_d;
    logic [23:0] edit_buf_d, wr_data_d;
    logic        edit_valid_d, wr_req_d;
    logic [7:0]  sel_field, stepped_field;
    logic        any_btn;

    assign any_btn = btn_mode | btn_left | btn_right | btn_up | btn_down;

    always_comb begin
        case (cursor_location)
            2'd0:    sel_field = edit_buf[23:16];
            2'd1:    sel_field = edit_buf[15:8];
            default: sel_field = edit_buf[7:0];
        endcase
    end

    // up has priority over down, so inc simply follows btn_up.
    bcd_field_step u_step (
        .value    (sel_field),
        .min_val  (field_min(config_mode, cursor_location)),
        .max_val  (field_max(config_mode, cursor_location)),
        .inc      (btn_up),
        .next_val (stepped_field)
    );

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        config_mode_d = config_mode;
        cursor_d      = cursor_location;
        edit_buf_d    = edit_buf;
        edit_valid_d  = edit_valid;
        wr_req_d      = wr_req;
        wr_mode_d     = wr_mode;
        wr_data_d     = wr_data;
        case (state_q)
            ST_IDLE: begin
                if (btn_mode) begin
                    state_d       = ST_EDIT;
                    config_mode_d = MODE_HORA;
                    cursor_d      = 2'd0;
                    edit_buf_d    = live_hms;
                    edit_valid_d  = 1'b1;
                    tmo_d         = '0;
                end
            end
            ST_EDIT: begin
                tmo_d = any_btn ? '0 : tmo_q + 30'd1;
                if (btn_mode) begin
                    state_d      = ST_WRITE;
                    wr_req_d     = 1'b1;
                    wr_mode_d    = config_mode;
                    wr_data_d    = edit_buf;
                    edit_valid_d = 1'b0;
                end else if (btn_left) begin
                    cursor_d = (cursor_location == 2'd0) ? 2'd2 : cursor_location - 2'd1;
                end else if (btn_right) begin
                    cursor_d = (cursor_location == 2'd2) ? 2'd0 : cursor_location + 2'd1;
                end else if (btn_up || btn_down) begin
                    case (cursor_location)
                        2'd0:    edit_buf_d[23:16] = stepped_field;
                        2'd1:    edit_buf_d[15:8]  = stepped_field;
                        default: edit_buf_d[7:0]   = stepped_field;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = ST_IDLE;
                    config_mode_d = MODE_NORMAL;
                    edit_valid_d  = 1'b0;
                    tmo_d         = '0;
                end
            end
            ST_WRITE: begin
                // Timeout counter and buttons are frozen until the ack arrives.
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    if (wr_mode == MODE_TIMER) begin
                        state_d       = ST_IDLE;
                        config_mode_d = MODE_NORMAL;
                    end else begin
                        state_d       = ST_EDIT;
                        config_mode_d = wr_mode + 2'd1;
                        cursor_d      = 2'd0;
                        edit_buf_d    = (wr_mode == MODE_HORA) ? live_date : live_timer;
                        edit_valid_d  = 1'b1;
                        tmo_d         = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            tmo_q           <= '0;
            config_mode     <= MODE_NORMAL;
            cursor_location <= 2'd0;
            edit_buf        <= '0;
            edit_valid      <= 1'b0;
            wr_req          <= 1'b0;
            wr_mode         <= 2'd0;
            wr_data         <= '0;
        end else begin
            state_q         <= state_d;
            tmo_q           <= tmo_d;
            config_mode     <= config_mode_d;
            cursor_location <= cursor_d;
            edit_buf        <= edit_buf_d;
            edit_valid      <= edit_valid_d;
            wr_req          <= wr_req_d;
            wr_mode         <= wr_mode_d;
            wr_data         <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_config_mode_ctrl.sv
// Bench for config_mode_ctrl: a decimal-field reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_config_mode_ctrl;

    localparam int TMO = 16;
    localparam logic [4:0] B_MODE = 5'b10000, B_LEFT = 5'b01000, B_RIGHT = 5'b00100,
                           B_UP = 5'b00010, B_DOWN = 5'b00001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 0, btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0;
    logic [23:0] live_hms = 24'h235958, live_date = 24'h011299, live_timer = 24'h012345;
    logic        wr_ack = 1'b0;
    logic [1:0]  config_mode, cursor_location, wr_mode;
    logic [23:0] edit_buf, wr_data;
    logic        edit_valid, wr_req;

    int n_vec = 0;
    int n_miss = 0;

    config_mode_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down),
        .live_hms(live_hms), .live_date(live_date), .live_timer(live_timer),
        .wr_ack(wr_ack),
        .config_mode(config_mode), .cursor_location(cursor_location),
        .edit_buf(edit_buf), .edit_valid(edit_valid),
        .wr_req(wr_req), .wr_mode(wr_mode), .wr_data(wr_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: fields held as decimal integers, limits as plain ranges.
    typedef struct {
        int          mode;
        int          cur;
        int          f[3];
        int          quiet;
        int          wmode;
        logic [23:0] wdata;
        bit          edit;
        bit          write;
    } model_t;

    model_t m;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int lo_lim(input int mode, input int f);
        if (mode == 2) return (f == 2) ? 0 : 1;
        return 0;
    endfunction

    function automatic int hi_lim(input int mode, input int f);
        if (mode == 2) return (f == 0) ? 31 : ((f == 1) ? 12 : 99);
        return (f == 0) ? 23 : 59;
    endfunction

    function automatic logic [23:0] model_buf(input model_t s);
        return {int2bcd(s.f[0]), int2bcd(s.f[1]), int2bcd(s.f[2])};
    endfunction

    function automatic model_t model_load(input model_t s, input logic [23:0] src);
        model_t r = s;
        r.f[0] = bcd2int(src[23:16]);
        r.f[1] = bcd2int(src[15:8]);
        r.f[2] = bcd2int(src[7:0]);
        r.cur = 0;
        r.quiet = 0;
        r.edit = 1'b1;
        return r;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.cur = 0; r.quiet = 0; r.wmode = 0; r.wdata = '0;
        r.f[0] = 0; r.f[1] = 0; r.f[2] = 0;
        r.edit = 1'b0; r.write = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t s);
        model_t r = s;
        int c;
        if (s.write) begin
            if (wr_ack) begin
                r.write = 1'b0;
                if (s.wmode == 3) r.mode = 0;
                else begin
                    r.mode = s.wmode + 1;
                    r = model_load(r, (s.wmode == 1) ? live_date : live_timer);
                end
            end
        end else if (s.edit) begin
            c = s.cur;
            if (btn_mode) begin
                r.write = 1'b1; r.edit = 1'b0; r.wmode = s.mode; r.wdata = model_buf(s);
            end else if (btn_left)  r.cur = (c + 2) % 3;
            else if (btn_right)     r.cur = (c + 1) % 3;
            else if (btn_up)        r.f[c] = (s.f[c] >= hi_lim(s.mode, c)) ? lo_lim(s.mode, c) : s.f[c] + 1;
            else if (btn_down)      r.f[c] = (s.f[c] <= lo_lim(s.mode, c)) ? hi_lim(s.mode, c) : s.f[c] - 1;
            if (btn_mode | btn_left | btn_right | btn_up | btn_down) r.quiet = 0;
            else begin
                r.quiet = s.quiet + 1;
                if (r.quiet == TMO) begin
                    r.edit = 1'b0;
                    r.mode = 0;
                end
            end
        end else if (btn_mode) begin
            r.mode = 1;
            r = model_load(r, live_hms);
        end
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= model_step(m);
    end

    always @(negedge clock) begin
        check("config_mode", 32'(config_mode), 32'(m.mode));
        check("edit_valid", 32'(edit_valid), 32'(m.edit));
        check("wr_req", 32'(wr_req), 32'(m.write));
        if (m.edit) begin
            check("cursor_location", 32'(cursor_location), 32'(m.cur));
            check("edit_buf", 32'(edit_buf), 32'(model_buf(m)));
        end
        if (m.write) begin
            check("wr_mode", 32'(wr_mode), 32'(m.wmode));
            check("wr_data", 32'(wr_data), 32'(m.wdata));
        end
    end

    task automatic pulse(input logic [4:0] b);
        {btn_mode, btn_left, btn_right, btn_up, btn_down} = b;
        @(negedge clock);
        {btn_mode, btn_left, btn_right, btn_up, btn_down} = 5'b0;
    endtask

    task automatic count_edit(output int n);
        n = 0;
        while (edit_valid && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi_cnt;
        int n;
        repeat (2) @(negedge clock);
        check("rst config_mode", 32'(config_mode), 32'd0);
        check("rst edit_valid", 32'(edit_valid), 32'd0);
        check("rst wr_req", 32'(wr_req), 32'd0);
        check("rst edit_buf", 32'(edit_buf), 32'd0);
        check("rst wr_data", 32'(wr_data), 32'd0);
        check("rst cursor", 32'(cursor_location), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        wr_ack = 1'b1; @(negedge clock); wr_ack = 1'b0;
        pulse(B_UP);
        check("idle ignores", 32'(config_mode), 32'd0);

        // First edit in hora mode
        pulse(B_MODE);
        check("entry mode", 32'(config_mode), 32'd1);
        check("entry buf", 32'(edit_buf), 32'h235958);
        check("entry valid", 32'(edit_valid), 32'd1);
        pulse(B_UP);
        check("HH wrap up", 32'(edit_buf), 32'h005958);
        pulse(B_DOWN);
        check("HH wrap down", 32'(edit_buf), 32'h235958);
        pulse(B_LEFT);
        check("left from 0", 32'(cursor_location), 32'd2);
        pulse(B_UP); pulse(B_UP);
        check("SS wrap up", 32'(edit_buf), 32'h235900);
        pulse(B_RIGHT);
        pulse(B_UP | B_RIGHT);
        check("up+right cursor", 32'(cursor_location), 32'd1);
        check("up+right buf", 32'(edit_buf), 32'h235900);

        // Write with delayed ack; up pulses during the wait are ignored
        live_hms = 24'h111111;
        pulse(B_MODE);
        hi_cnt = wr_req ? 1 : 0;
        check("wr_mode hora", 32'(wr_mode), 32'd1);
        check("wr_data hora", 32'(wr_data), 32'h235900);
        for (int i = 0; i < 5; i++) begin
            btn_up = (i == 2);
            @(negedge clock);
            btn_up = 1'b0;
            if (wr_req) hi_cnt++;
            check("wr_data held", 32'(wr_data), 32'h235900);
        end
        wr_ack = 1'b1; @(negedge clock); wr_ack = 1'b0;
        check("wr_req high cycles", 32'(hi_cnt), 32'd6);
        check("wr_req dropped", 32'(wr_req), 32'd0);
        check("fecha mode", 32'(config_mode), 32'd2);
        check("fecha load", 32'(edit_buf), 32'h011299);

        // Date field limits
        pulse(B_DOWN);
        check("DAY wrap down", 32'(edit_buf[23:16]), 32'h31);
        pulse(B_RIGHT); pulse(B_UP);
        check("MES wrap up", 32'(edit_buf), 32'h310199);
        pulse(B_LEFT); pulse(B_LEFT);
        check("left 0 to 2", 32'(cursor_location), 32'd2);
        pulse(B_UP);
        check("YEAR wrap up", 32'(edit_buf[7:0]), 32'h00);
        pulse(B_DOWN);

        // Mode and up together commit the unmodified value; ack in first cycle
        pulse(B_MODE | B_UP);
        check("mode+up wr_data", 32'(wr_data), 32'h310199);
        check("mode+up wr_mode", 32'(wr_mode), 32'd2);
        wr_ack = 1'b1; @(negedge clock); wr_ack = 1'b0;
        check("fast ack wr_req", 32'(wr_req), 32'd0);
        check("timer mode", 32'(config_mode), 32'd3);
        check("timer load", 32'(edit_buf), 32'h012345);
        pulse(B_UP);
        pulse(B_MODE);
        check("timer wr_data", 32'(wr_data), 32'h022345);
        wr_ack = 1'b1; @(negedge clock); wr_ack = 1'b0;
        check("timer done mode", 32'(config_mode), 32'd0);
        check("timer done valid", 32'(edit_valid), 32'd0);

        // Inactivity timeout, then a restart from a button at cycle 10
        pulse(B_MODE);
        count_edit(n);
        check("timeout cycles", 32'(n), 32'd16);
        pulse(B_MODE);
        repeat (9) @(negedge clock);
        pulse(B_UP);
        count_edit(n);
        check("timeout restart", 32'(n), 32'd16);
        check("timeout mode", 32'(config_mode), 32'd0);

        // Asynchronous reset during a pending write
        pulse(B_MODE);
        pulse(B_MODE);
        check("pre-reset wr_req", 32'(wr_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async wr_req", 32'(wr_req), 32'd0);
        check("async config_mode", 32'(config_mode), 32'd0);
        check("async edit_valid", 32'(edit_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        wr_ack = 1'b1; @(negedge clock); wr_ack = 1'b0;
        check("post-reset idle", 32'(config_mode), 32'd0);
        pulse(B_MODE);
        check("post-reset entry", 32'(config_mode), 32'd1);
        check("post-reset buf", 32'(edit_buf), 32'h111111);
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/config_mode_ctrl.md
# config_mode_ctrl

Configuration-mode controller for the clock screen. It turns debounced push-button pulses into the screen's `config_mode` and `cursor_location` selectors and holds a three-field BCD edit buffer that the display shows while editing. When the user leaves a configuration page, it commits the edited values to the RTC write port through a req/ack handshake. It sits between the button debouncers, the RTC interface and the clock-screen top level.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000_000: inactivity limit in EDIT (10 s at 100 MHz); counter is 30 bits.
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  reset; one clock, reset is asynchronous and active-low.
- `btn_mode, btn_left, btn_right, btn_up, btn_down`  in  1 each  single-cycle debounced pulses.
- `live_hms`  in  24  BCD HH:MM:SS from the RTC, in the order `[23:16]` HH, `[15:8]` MM, `[7:0]` SS.
- `live_date`  in  24  BCD DAY:MES:YEAR, same ordering.
- `live_timer`  in  24  BCD timer HH:MM:SS, same ordering.
- `wr_ack`  in  1  RTC write accepted.
- `config_mode`  out  2  0 = normal, 1 = hora, 2 = fecha, 3 = timer.
- `cursor_location`  out  2  selected field 0..2; 0 is the leftmost field.
- `edit_buf`  out  24  BCD edit values, same field order as the `live_*` inputs.
- `edit_valid`  out  1  high while in EDIT; the display then uses `edit_buf` in place of live data.
- `wr_req`  out  1  write request.
- `wr_mode`  out  2  target register group (1/2/3).
- `wr_data`  out  24  BCD payload.

## Operation
- States: IDLE, EDIT, WRITE.
- Reset values: state IDLE; `config_mode` 0; `cursor_location` 0; `edit_buf` 0; `edit_valid` 0; `wr_req` 0; `wr_mode` 0; `wr_data` 0; timeout counter 0.
- **IDLE**
  - `btn_mode` moves to EDIT with `config_mode` = 1 and `cursor_location` = 0.
  - `edit_buf` is loaded from `live_hms`.
  - All other buttons are ignored.
- **EDIT, buttons:** only one button is acted on per cycle, by priority mode > left > right > up > down.
  - right: cursor advances 0→1→2→0.
  - left: cursor moves 0→2→1→0.
  - up: increments the selected field; the maximum wraps to the minimum.
  - down: decrements the selected field; the minimum wraps to the maximum.
- **EDIT, field limits (BCD):**
  - Modes 1 and 3: HH 00–23, MM 00–59, SS 00–59.
  - Mode 2: DAY 01–31, MES 01–12, YEAR 00–99.
  - No month-length check is done; the RTC side handles validation.
- **EDIT, mode press:** moves to WRITE with `wr_mode` = `config_mode` and `wr_data` = `edit_buf`.
- **EDIT, timeout:** the counter clears on any button pulse and increments otherwise. When it reaches `TIMEOUT_CYCLES-1`, the block goes to IDLE with `config_mode` 0 and no write.
- **WRITE**
  - `wr_req` is held high; `wr_mode`, `wr_data` and the displayed `config_mode` stay frozen.
  - All buttons are ignored and the timeout is halted.
  - The handshake completes in a cycle where `wr_req && wr_ack`.
  - On completion, if `wr_mode` = 3, go to IDLE with `config_mode` 0.
  - Otherwise go to EDIT with `config_mode` = `wr_mode+1`, cursor 0, and `edit_buf` loaded from the matching `live_*` input (`live_date` for 2, `live_timer` for 3).
- `edit_valid` is 1 only in EDIT.
- A `wr_ack` seen outside WRITE is ignored.
- Reset asserted mid-WRITE drops `wr_req` immediately (asynchronously) and discards the transaction.

## Timing
- All outputs are registered. A button pulse in cycle n is reflected on the outputs in cycle n+1.
- `wr_req` rises in the cycle after the mode press.
- `wr_ack` is allowed in that same first cycle; `wr_req` is then low in the following cycle.
- `wr_req` falls in the cycle after the ack, together with the state change.
- The `live_*` inputs are sampled only on the load edge; they are not tracked during EDIT.

## Structure
- A shared package `clock_screen_pkg` holds:
  - mode encodings `MODE_NORMAL`, `MODE_HORA`, `MODE_FECHA`, `MODE_TIMER`;
  - the state encoding;
  - the BCD min/max constants per mode and field.
- Sub-module `bcd_field_step`: combinational. Inputs are an 8-bit BCD value, min, max and inc/dec; output is the next BCD value with wrap.
- The FSM, cursor, timeout counter and handshake stay in `config_mode_ctrl`.

## Test plan
- **Reset entry and first edit.**
  - Stimulus: release reset with `live_hms` = 0x235958, then pulse mode.
  - Required: `config_mode` = 1, `edit_buf` = 0x235958 and `edit_valid` = 1 one cycle later.
  - Stimulus: pulse up on field 0.
  - Required: HH = 00, giving 0x005958.
- **Field limits.**
  - Stimulus: in mode 2 with DAY = 01, pulse down.
  - Required: 0x31.
  - Stimulus: move cursor to MES = 12, pulse up.
  - Required: 0x01.
  - Stimulus: pulse left from cursor 0.
  - Required: cursor = 2.
- **Write handshake.**
  - Stimulus: mode press in mode 1, hold `wr_ack` low for 5 cycles, then pulse it.
  - Required: `wr_req` high for 6 cycles with `wr_mode` = 1 and `wr_data` constant; then mode 2 with `edit_buf` = `live_date`.
  - Stimulus: up pulses during the wait.
  - Required: ignored.
- **Simultaneous buttons.**
  - Stimulus: up and right in the same cycle.
  - Required: only the cursor moves.
  - Stimulus: mode and up in the same cycle.
  - Required: WRITE carries the unmodified value.
- **Timeout.**
  - Stimulus: `TIMEOUT_CYCLES` = 16, enter EDIT and stay idle.
  - Required: `config_mode` returns to 0 after 16 cycles with no `wr_req`.
  - Stimulus: a button at cycle 10.
  - Required: the timeout restarts.
- **Reset during write.**
  - Stimulus: assert reset while `wr_req` = 1.
  - Required: `wr_req`, `config_mode` and `edit_valid` go to 0 without waiting for a clock edge; after release, the block is in IDLE.
